// File: rtl/wb_stage_pipe_pkg.sv
// Shared widths and FSM state encoding for the write-back stage.
package wb_stage_pipe_pkg;

    localparam int unsigned DATA_BUS     = 32;
    localparam int unsigned ADDR_BUS     = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam int unsigned MEM_SEL_BUS  = DATA_BUS / 8;

    // IDLE accepts new work; LOAD_WAIT waits on the RAM for load data.
    typedef enum logic [0:0] {
        WbIdle     = 1'b0,
        WbLoadWait = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Load-data alignment: byte-lane legality check, lane extraction and
// sign/zero extension. Purely combinational.
module wb_load_align #(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned SelW  = DATA_W / 8
) (
    input  logic [SelW-1:0]   sel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sign_ext_i,
    output logic              legal_o,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [SelW-1:0] AllLanes = '1;

    int                n;
    int                lo;
    logic              found;
    logic [DATA_W-1:0] shifted;

    // Count lanes, locate the lowest one, then extract and extend the field.
    always_comb begin
        n       = 0;
        lo      = 0;
        found   = 1'b0;
        legal_o = 1'b0;
        for (int i = 0; i < int'(SelW); i++) begin
            if (sel_i[i]) begin
                n = n + 1;
                if (!found) begin
                    lo = i;
                end
                found = 1'b1;
            end
        end
        // Contiguous run of n lanes, naturally aligned to its own size.
        if (n != 0) begin
            legal_o = ((n == 1) || (n == 2) || (n == int'(SelW))) &&
                      ((sel_i >> lo) == (AllLanes >> (int'(SelW) - n))) &&
                      ((lo % n) == 0);
        end
        shifted = data_i >> (8 * lo);
        if (n == 1) begin
            data_o = {{(DATA_W - 8){sign_ext_i & shifted[7]}}, shifted[7:0]};
        end else if (n == 2) begin
            data_o = {{(DATA_W - 16){sign_ext_i & shifted[15]}}, shifted[15:0]};
        end else begin
            data_o = shifted;
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: MEM/WB register, load alignment and
// register-file commit. Loads wait for ram_rvalid with a timeout.
// Optional trace ports are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_BUS,
    parameter int unsigned ADDR_W       = ADDR_BUS,
    parameter int unsigned REG_ADDR_W   = REG_ADDR_BUS,
    parameter int unsigned SEL_W        = DATA_W / 8,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_read_flag,
    input  logic                  mem_sign_ext_flag,
    input  logic [SEL_W-1:0]      mem_sel,
    input  logic [DATA_W-1:0]     result_in,
    input  logic                  reg_write_en_in,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
    input  logic [ADDR_W-1:0]     current_pc_addr_in,
    input  logic [DATA_W-1:0]     ram_read_data,
    input  logic                  ram_rvalid,
    output logic [DATA_W-1:0]     result_out,
    output logic                  reg_write_en_out,
    output logic [REG_ADDR_W-1:0] reg_write_addr_out,
    output logic                  stall_req,
    output logic                  load_err
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic                  debug_reg_write_en,
    output logic [ADDR_W-1:0]     debug_pc_addr_out,
    output logic [31:0]           debug_retire_cnt
`endif
);

    localparam int unsigned CntW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(LOAD_TIMEOUT);

    wb_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ld_sign_q, ld_sign_d;
    logic [SEL_W-1:0]      ld_sel_q, ld_sel_d;
    logic                  ld_wen_q, ld_wen_d;
    logic [REG_ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic                  err_q, err_d;
    logic                  ld_legal;
    logic [DATA_W-1:0]     ld_data;

`ifdef WB_DEBUG_TRACE_EN
    logic [ADDR_W-1:0]     ld_pc_q, ld_pc_d;
    logic [ADDR_W-1:0]     dbg_pc_q, dbg_pc_d;
    logic [31:0]           retire_q, retire_d;
`else
    logic                  unused_pc;
    assign unused_pc = ^current_pc_addr_in;
`endif

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .sel_i      (ld_sel_q),
        .data_i     (ram_read_data),
        .sign_ext_i (ld_sign_q),
        .legal_o    (ld_legal),
        .data_o     (ld_data)
    );

    // Next-state: flush first, then accept in IDLE, then data/timeout in LOAD_WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_sign_d = ld_sign_q;
        ld_sel_d  = ld_sel_q;
        ld_wen_d  = ld_wen_q;
        ld_addr_d = ld_addr_q;
        result_d  = result_q;
        waddr_d   = waddr_q;
        wen_d     = 1'b0;
        err_d     = 1'b0;
`ifdef WB_DEBUG_TRACE_EN
        ld_pc_d   = ld_pc_q;
        dbg_pc_d  = dbg_pc_q;
        retire_d  = retire_q;
`endif
        if (flush) begin
            state_d = WbIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WbIdle: begin
                    if (in_valid) begin
                        if (mem_read_flag) begin
                            state_d   = WbLoadWait;
                            cnt_d     = '0;
                            ld_sign_d = mem_sign_ext_flag;
                            ld_sel_d  = mem_sel;
                            ld_wen_d  = reg_write_en_in;
                            ld_addr_d = reg_write_addr_in;
`ifdef WB_DEBUG_TRACE_EN
                            ld_pc_d   = current_pc_addr_in;
`endif
                        end else begin
                            result_d = result_in;
                            waddr_d  = reg_write_addr_in;
                            wen_d    = reg_write_en_in && (|reg_write_addr_in);
`ifdef WB_DEBUG_TRACE_EN
                            dbg_pc_d = current_pc_addr_in;
`endif
                        end
                    end
                end
                WbLoadWait: begin
                    if (ram_rvalid) begin
                        state_d = WbIdle;
                        if (ld_legal) begin
                            result_d = ld_data;
                            waddr_d  = ld_addr_q;
                            wen_d    = ld_wen_q && (|ld_addr_q);
`ifdef WB_DEBUG_TRACE_EN
                            dbg_pc_d = ld_pc_q;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cnt_q + 1'b1 == TimeoutVal) begin
                        state_d = WbIdle;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = WbIdle;
            endcase
        end
`ifdef WB_DEBUG_TRACE_EN
        if (wen_d) begin
            retire_d = retire_q + 32'd1;
        end
`endif
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WbIdle;
            cnt_q     <= '0;
            ld_sign_q <= 1'b0;
            ld_sel_q  <= '0;
            ld_wen_q  <= 1'b0;
            ld_addr_q <= '0;
            result_q  <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            err_q     <= 1'b0;
`ifdef WB_DEBUG_TRACE_EN
            ld_pc_q   <= '0;
            dbg_pc_q  <= '0;
            retire_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_sign_q <= ld_sign_d;
            ld_sel_q  <= ld_sel_d;
            ld_wen_q  <= ld_wen_d;
            ld_addr_q <= ld_addr_d;
            result_q  <= result_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            err_q     <= err_d;
`ifdef WB_DEBUG_TRACE_EN
            ld_pc_q   <= ld_pc_d;
            dbg_pc_q  <= dbg_pc_d;
            retire_q  <= retire_d;
`endif
        end
    end

    assign in_ready           = (state_q == WbIdle);
    assign stall_req          = (state_q == WbLoadWait);
    assign result_out         = result_q;
    assign reg_write_en_out   = wen_q;
    assign reg_write_addr_out = waddr_q;
    assign load_err           = err_q;
`ifdef WB_DEBUG_TRACE_EN
    assign debug_reg_write_en = wen_q;
    assign debug_pc_addr_out  = dbg_pc_q;
    assign debug_retire_cnt   = retire_q;
`endif

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered, parametrised write-back stage: MEM/WB pipeline register, load-data alignment and extension, and register-file write commit in one block.
- Sits between the MEM stage and the register file.
- Handles synchronous RAMs with variable read latency through a valid handshake, a stall request and a load timeout.
- Successor to the pass-through write-back: adds width, lane and latency generalisation.

Parameters:
- DATA_W, 32, datapath and RAM word width; must be a multiple of 16.
- ADDR_W, 32, PC width.
- REG_ADDR_W, 5, register-file address width.
- SEL_W, DATA_W/8, byte-lane select width.
- LOAD_TIMEOUT, 15, maximum cycles spent in LOAD_WAIT before the load is abandoned (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- mem_read_flag  in  1  instruction is a load.
- mem_sign_ext_flag  in  1  sign-extend load data (0 = zero-extend).
- mem_sel  in  SEL_W  byte lanes read.
- result_in  in  DATA_W  EX/MEM result for non-loads.
- reg_write_en_in  in  1  register-file write enable.
- reg_write_addr_in  in  REG_ADDR_W  destination register.
- current_pc_addr_in  in  ADDR_W  PC of the instruction.
- ram_read_data  in  DATA_W  RAM read word.
- ram_rvalid  in  1  ram_read_data valid this cycle.
- result_out  out  DATA_W  write-back data.
- reg_write_en_out  out  1  one-cycle commit pulse.
- reg_write_addr_out  out  REG_ADDR_W  write-back address.
- stall_req  out  1  stall upstream stages.
- load_err  out  1  one-cycle pulse: bad mem_sel or timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 except in_ready=1; timeout counter=0.
- FSM states are IDLE and LOAD_WAIT.
- in_ready = (state==IDLE). stall_req = (state==LOAD_WAIT).
- Accept = in_valid && in_ready && !flush.
- Non-load accepted in IDLE: the next cycle drives result_out=result_in, reg_write_en_out=reg_write_en_in, reg_write_addr_out=reg_write_addr_in, for 1 cycle. Latency is 1. FSM stays in IDLE, so back-to-back acceptance is allowed.
- Load accepted (mem_read_flag=1):
  - Capture control, address, mem_sel and PC.
  - Go to LOAD_WAIT and clear the counter.
  - ram_rvalid is ignored in IDLE and in the accept cycle itself.
- In LOAD_WAIT:
  - If ram_rvalid=1: align/extend ram_read_data, commit next cycle, return to IDLE.
  - Otherwise increment the counter. When counter==LOAD_TIMEOUT, return to IDLE and pulse load_err next cycle with reg_write_en_out=0.
- Alignment:
  - n = popcount(mem_sel), lo = index of lowest set bit.
  - Legal only if set bits are contiguous, n∈{1,2,SEL_W}, and lo is a multiple of n.
  - Field = ram_read_data[8*lo +: 8*n].
  - Illegal mem_sel: no write, load_err pulse at commit time.
- Extension: if mem_sign_ext_flag=1, replicate the field MSB to DATA_W; otherwise zero-fill.
- reg_write_addr==0: reg_write_en_out is forced 0; result_out is still driven.
- reg_write_en_out and load_err are single-cycle pulses. result_out and reg_write_addr_out hold their last value otherwise.
- flush=1, any state: next state IDLE, next-cycle reg_write_en_out=0 and load_err=0, pending load dropped. flush has priority over accept and over ram_rvalid.
- Reset during LOAD_WAIT: immediate IDLE; the late ram_rvalid is ignored.

Optional Feature:
- Macro WB_DEBUG_TRACE_EN.
- When defined, adds:
  - debug_reg_write_en out 1 (equal to reg_write_en_out).
  - debug_pc_addr_out out ADDR_W (PC of the committing instruction, registered alongside).
  - debug_retire_cnt out 32: count of commits with reg_write_en_out=1; reset 0; wraps at 2^32.
- When undefined, these ports and registers do not exist and there is no behavioural change.

Decomposition:
- Shared package bus.v: DATA_BUS, ADDR_BUS, REG_ADDR_BUS, MEM_SEL_BUS widths and localparams WB_IDLE / WB_LOAD_WAIT.
- One sub-module, wb_load_align: combinational mem_sel legality check, lane extraction and sign/zero extension; parametrised by DATA_W.

Test Plan:
- Non-load: result_in=0x12345678, addr=5, en=1 -> next cycle result_out=0x12345678, reg_write_en_out=1 for 1 cycle, addr=5.
- Signed byte load: sel=0100, data=0xAA80CC11, sign=1, ram_rvalid 3 cycles later -> stall_req high 3 cycles; result_out=0xFFFFFF80.
- Unsigned halfword load: sel=1100, data=0x8001FFFF, sign=0 -> result_out=0x00008001.
- Illegal and timeout loads:
  - sel=0110 -> load_err pulse, reg_write_en_out=0.
  - No ram_rvalid for LOAD_TIMEOUT=15 cycles -> load_err pulse, return to IDLE, in_ready=1.
- Flush mid-load: flush in 2nd LOAD_WAIT cycle, ram_rvalid next cycle -> no commit, in_ready=1.
- Write to $0: addr=0, en=1 -> reg_write_en_out stays 0.
- Async reset mid-load: reset asserted while in LOAD_WAIT -> all outputs 0 immediately.
